// File: rtl/cmd_seq_pkg.sv
// Shared definitions for the UART command sequencer.
//   seq_state_t : playback FSM states
//   CMD_GO/STOP : well-known command bytes used by the BLE host scripts
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_DONE = 3'd3,
    DELAY     = 3'd4,
    DRAIN     = 3'd5
  } seq_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/cmd_seq_table.sv
// Command table: DEPTH entries of {command byte, post-delay}.
//   clk             : system clock
//   wr_en/wr_addr   : write strobe and address (addresses >= DEPTH are dropped)
//   wr_cmd/wr_dly   : entry contents to store
//   rd_addr         : read address (the sequencer's current index)
//   rd_cmd/rd_dly   : combinational read data
// Contents are deliberately not reset so a script survives a sequencer reset.
module cmd_seq_table
  import cmd_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int DLY_W  = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_cmd,
  input  logic [DLY_W-1:0]  wr_dly,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_cmd,
  output logic [DLY_W-1:0]  rd_dly
);

  logic [DATA_W-1:0] cmd_mem_r [DEPTH];
  logic [DLY_W-1:0]  dly_mem_r [DEPTH];

  // Single write port; a same-cycle read of the written address still sees old data.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      cmd_mem_r[wr_addr] <= wr_cmd;
      dly_mem_r[wr_addr] <= wr_dly;
    end
  end

  assign rd_cmd = cmd_mem_r[rd_addr];
  assign rd_dly = dly_mem_r[rd_addr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Scripted command-byte sequencer in front of a uart_tx.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_*            : table write port
//   num_entries     : entries to play, sampled on start (clamped to DEPTH)
//   loop_en         : wrap to entry 0 after the last entry (sampled at each wrap)
//   start / abort   : begin playback (IDLE only) / stop playback (abort wins)
//   tx_done         : level from uart_tx, cleared by uart_tx after trmt
//   trmt, tx_data   : transmit request and byte to uart_tx
//   busy            : high in every state except IDLE
//   seq_done        : one-cycle pulse on normal completion
//   cur_idx         : entry currently being played
module uart_cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int DLY_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_cmd,
  input  logic [DLY_W-1:0]  wr_dly,
  input  logic [AW:0]       num_entries,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  input  logic              tx_done,
  output logic              trmt,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              seq_done,
  output logic [AW-1:0]     cur_idx
);

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);

  seq_state_t        state_r, next_state_s;
  logic [AW-1:0]     cur_idx_r;
  logic [AW:0]       num_r;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              busy_r, seq_done_r;
  logic              ign_r;       // tx_done still stale this cycle
  logic [DATA_W-1:0] rd_cmd_s;
  logic [DLY_W-1:0]  rd_dly_s;
  logic              last_s, advance_s, done_s;
  seq_state_t        adv_state_s;

  cmd_seq_table #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .DLY_W(DLY_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_cmd  (wr_cmd),
    .wr_dly  (wr_dly),
    .rd_addr (cur_idx_r),
    .rd_cmd  (rd_cmd_s),
    .rd_dly  (rd_dly_s)
  );

  // Current entry is the last one of this pass.
  assign last_s = (({1'b0, cur_idx_r} + (AW+1)'(1'b1)) == num_r);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort is checked first in every state.
  always_comb begin
    next_state_s = state_r;
    advance_s    = 1'b0;
    done_s       = 1'b0;
    if (last_s && !loop_en) begin
      adv_state_s = IDLE;
    end else begin
      adv_state_s = LOAD;
    end
    case (state_r)
      IDLE: begin
        if (abort) begin
          next_state_s = IDLE;
        end else if (start && (num_entries != '0)) begin
          next_state_s = LOAD;
        end else if (start) begin
          done_s       = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // The byte already handed to uart_tx is never cancelled.
        if (abort) begin
          next_state_s = DRAIN;
        end else if (!ign_r && tx_done) begin
          if (dly_cnt_r == '0) begin
            advance_s    = 1'b1;
            done_s       = last_s && !loop_en;
            next_state_s = adv_state_s;
          end else begin
            next_state_s = DELAY;
          end
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      DELAY: begin
        if (abort) begin
          next_state_s = IDLE;
        end else if (dly_cnt_r <= DLY_W'(1'b1)) begin
          advance_s    = 1'b1;
          done_s       = last_s && !loop_en;
          next_state_s = adv_state_s;
        end else begin
          next_state_s = DELAY;
        end
      end
      DRAIN: begin
        if (!ign_r && tx_done) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Transmit request: only in SEND, suppressed by a same-cycle abort.
  always_comb begin
    trmt = 1'b0;
    if ((state_r == SEND) && !abort) begin
      trmt = 1'b1;
    end else begin
      trmt = 1'b0;
    end
  end

  // Datapath: index, sampled entry count, delay counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx_r  <= '0;
      num_r      <= '0;
      dly_cnt_r  <= '0;
      tx_data_r  <= '0;
      busy_r     <= 1'b0;
      seq_done_r <= 1'b0;
      ign_r      <= 1'b0;
    end else begin
      busy_r     <= (next_state_s != IDLE);
      seq_done_r <= done_s;
      // First cycle after trmt sees the previous byte's tx_done; an abort in
      // that cycle carries the same blindness into DRAIN.
      ign_r      <= (state_r == SEND) ||
                    ((state_r == WAIT_DONE) && (next_state_s == DRAIN) && ign_r);

      if ((state_r == IDLE) && (next_state_s == LOAD)) begin
        cur_idx_r <= '0;
        num_r     <= (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
      end else if (advance_s) begin
        cur_idx_r <= last_s ? '0 : (cur_idx_r + AW'(1'b1));
      end

      if ((state_r == LOAD) && (next_state_s == SEND)) begin
        tx_data_r <= rd_cmd_s;
        dly_cnt_r <= rd_dly_s;
      end else if ((state_r == DELAY) && (dly_cnt_r != '0)) begin
        dly_cnt_r <= dly_cnt_r - DLY_W'(1'b1);
      end
    end
  end

  assign tx_data  = tx_data_r;
  assign busy     = busy_r;
  assign seq_done = seq_done_r;
  assign cur_idx  = cur_idx_r;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer with a small uart_tx stand-in that raises
// tx_done TX_LEN cycles after trmt and (optionally) clears it one cycle late.
module tb_uart_cmd_sequencer;
  import cmd_seq_pkg::*;

  localparam int TX_LEN = 4;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_cmd;
  logic [23:0] wr_dly;
  logic [4:0]  num_entries;
  logic        loop_en, start, abort;
  logic        tx_done;
  logic        trmt, busy, seq_done;
  logic [7:0]  tx_data;
  logic [3:0]  cur_idx;

  uart_cmd_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd),
    .wr_dly(wr_dly), .num_entries(num_entries), .loop_en(loop_en),
    .start(start), .abort(abort), .tx_done(tx_done), .trmt(trmt),
    .tx_data(tx_data), .busy(busy), .seq_done(seq_done), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx stand-in
  logic stale;
  int   tx_cnt;
  logic trmt_d;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_done <= 1'b0;
      tx_cnt  <= 0;
      trmt_d  <= 1'b0;
    end else begin
      trmt_d <= trmt;
      if (trmt) tx_cnt <= TX_LEN;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
      if (trmt && !stale) tx_done <= 1'b0;
      else if (trmt_d && stale) tx_done <= 1'b0;
      else if (tx_cnt == 1 && !trmt) tx_done <= 1'b1;
    end
  end

  int n_chk = 0, n_pass = 0;

  // observation state
  int n_trmt, n_rise, n_done, first_trmt, second_trmt, first_rise, last_rise, done_cyc, start_cyc;
  logic [7:0] first_data, last_data;
  logic [3:0] last_idx;
  logic busy_at_done, busy_seen, prev_done;
  logic [7:0] td [8];
  logic [3:0] ti [8];

  typedef struct {
    logic [4:0] num;
    logic       stl;
    logic [7:0] c0, c1, c2;
    int         d0, d1, d2;
    int         exp_n;
    logic [7:0] exp_first, exp_last;
    int         exp_gap;   // second trmt minus first tx_done rise, -1 = n/a
    int         exp_lat;   // seq_done minus last tx_done rise (or start if no bytes)
  } vec_t;
  vec_t vec [6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_stats();
    n_trmt = 0; n_rise = 0; n_done = 0; first_trmt = 0; second_trmt = 0;
    first_rise = 0; last_rise = 0; done_cyc = 0; first_data = 8'h00;
    last_data = 8'h00; last_idx = 4'h0; busy_at_done = 1'b0; busy_seen = 1'b0;
    prev_done = tx_done;
  endtask

  task automatic watch();
    if (busy) busy_seen = 1'b1;
    if (trmt) begin
      n_trmt++;
      if (n_trmt == 1) begin first_data = tx_data; first_trmt = cyc; end
      if (n_trmt == 2) second_trmt = cyc;
      if (n_trmt <= 8) begin td[n_trmt-1] = tx_data; ti[n_trmt-1] = cur_idx; end
      last_data = tx_data;
      last_idx  = cur_idx;
    end
    if (tx_done && !prev_done) begin
      n_rise++;
      if (n_rise == 1) first_rise = cyc;
      last_rise = cyc;
    end
    prev_done = tx_done;
    if (seq_done) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic step();
    @(negedge clk);
    watch();
  endtask

  task automatic write_entry(input int a, input logic [7:0] c, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_cmd = c; wr_dly = 24'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic begin_play(input logic [4:0] num, input logic lp);
    clear_stats();
    num_entries = num; loop_en = lp; start = 1'b1; start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic finish_play(input string name);
    int k;
    k = 0;
    while (busy && k < BUDGET) begin step(); k++; end
    chk({name, "_timeout"}, (k < BUDGET), 1);
    repeat (6) step();
  endtask

  initial begin
    vec[0] = '{5'd2, 1'b0, CMD_GO, CMD_STOP, 8'h00, 5, 0, 0, 2, CMD_GO, CMD_STOP, 7, 1};
    vec[1] = '{5'd1, 1'b0, CMD_GO, CMD_STOP, 8'h00, 3, 0, 0, 1, CMD_GO, CMD_GO, -1, 4};
    vec[2] = '{5'd0, 1'b0, CMD_GO, CMD_STOP, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, -1, 1};
    vec[3] = '{5'd3, 1'b0, CMD_GO, CMD_STOP, 8'hA5, 0, 2, 1, 3, CMD_GO, 8'hA5, 2, 2};
    vec[4] = '{5'd2, 1'b1, CMD_GO, CMD_STOP, 8'h00, 5, 0, 0, 2, CMD_GO, CMD_STOP, 7, 1};
    vec[5] = '{5'd2, 1'b1, CMD_STOP, CMD_GO, 8'h00, 0, 0, 0, 2, CMD_STOP, CMD_GO, 2, 1};

    rst = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_cmd = 8'h00; wr_dly = 24'h0;
    num_entries = 5'd0; loop_en = 1'b0; start = 1'b0; abort = 1'b0; stale = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_cur_idx", cur_idx, 0);
    rst = 1'b0;
    step();

    // table-driven single-pass playback
    for (int v = 0; v < 6; v++) begin
      write_entry(0, vec[v].c0, vec[v].d0);
      write_entry(1, vec[v].c1, vec[v].d1);
      write_entry(2, vec[v].c2, vec[v].d2);
      stale = vec[v].stl;
      begin_play(vec[v].num, 1'b0);
      finish_play($sformatf("v%0d", v));
      chk($sformatf("v%0d_n_trmt", v), n_trmt, vec[v].exp_n);
      chk($sformatf("v%0d_trmt_per_done", v), n_rise, vec[v].exp_n);
      chk($sformatf("v%0d_n_done", v), n_done, 1);
      chk($sformatf("v%0d_busy_at_done", v), busy_at_done, 0);
      if (vec[v].exp_n > 0) begin
        chk($sformatf("v%0d_trmt_latency", v), first_trmt - start_cyc, 2);
        chk($sformatf("v%0d_first_data", v), first_data, vec[v].exp_first);
        chk($sformatf("v%0d_last_data", v), last_data, vec[v].exp_last);
        chk($sformatf("v%0d_done_lat", v), done_cyc - last_rise, vec[v].exp_lat);
      end else begin
        chk($sformatf("v%0d_done_lat", v), done_cyc - start_cyc, vec[v].exp_lat);
      end
      if (vec[v].exp_gap >= 0)
        chk($sformatf("v%0d_gap", v), second_trmt - first_rise, vec[v].exp_gap);
    end

    // looping: wrap once, then clear loop_en
    stale = 1'b0;
    write_entry(0, CMD_GO, 5);
    write_entry(1, CMD_STOP, 0);
    begin
      int k;
      begin_play(5'd2, 1'b1);
      k = 0;
      while (busy && k < BUDGET) begin
        step(); k++;
        if (n_trmt >= 3) loop_en = 1'b0;
      end
      chk("loop_timeout", (k < BUDGET), 1);
      repeat (6) step();
      chk("loop_n_trmt", n_trmt, 4);
      chk("loop_idx1", ti[1], 1);
      chk("loop_idx2", ti[2], 0);
      chk("loop_data2", td[2], CMD_GO);
      chk("loop_data3", td[3], CMD_STOP);
      chk("loop_n_done", n_done, 1);
    end

    // abort during DELAY
    begin
      int k;
      begin_play(5'd2, 1'b0);
      k = 0;
      while (n_rise < 1 && k < BUDGET) begin step(); k++; end
      step();
      chk("abd_busy_before", busy, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abd_busy_after", busy, 0);
      repeat (30) step();
      chk("abd_n_trmt", n_trmt, 1);
      chk("abd_n_done", n_done, 0);
    end

    // abort during WAIT_DONE: drain the byte in flight
    begin
      int k, drop;
      begin_play(5'd2, 1'b0);
      k = 0;
      while (n_trmt < 1 && k < BUDGET) begin step(); k++; end
      step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abw_busy_drain", busy, 1);
      k = 0;
      while (busy && k < BUDGET) begin step(); k++; end
      drop = cyc;
      chk("abw_drop_after_done", drop - last_rise, 1);
      repeat (10) step();
      chk("abw_n_trmt", n_trmt, 1);
      chk("abw_n_done", n_done, 0);
    end

    // start and abort together in IDLE
    clear_stats();
    num_entries = 5'd2; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    repeat (10) step();
    chk("sa_busy_seen", busy_seen, 0);
    chk("sa_n_trmt", n_trmt, 0);
    chk("sa_n_done", n_done, 0);

    // reset in the middle of WAIT_DONE
    begin
      int k;
      begin_play(5'd2, 1'b0);
      k = 0;
      while (n_trmt < 1 && k < BUDGET) begin step(); k++; end
      step(); step();
      rst = 1'b1;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_trmt", trmt, 0);
      chk("mr_seq_done", seq_done, 0);
      chk("mr_tx_data", tx_data, 0);
      chk("mr_cur_idx", cur_idx, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      begin_play(5'd2, 1'b0);
      finish_play("mr_replay");
      chk("mr_replay_first", first_data, CMD_GO);
      chk("mr_replay_n_trmt", n_trmt, 2);
      chk("mr_replay_done", n_done, 1);
    end

    // num_entries above DEPTH is clamped
    for (int i = 0; i < 16; i++) write_entry(i, 8'h20 + 8'(i), 0);
    begin_play(5'd31, 1'b0);
    finish_play("clamp");
    chk("clamp_n_trmt", n_trmt, 16);
    chk("clamp_last_data", last_data, 8'h2F);
    chk("clamp_last_idx", last_idx, 15);
    chk("clamp_n_done", n_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
